pipe_stage_skid_reg: RTL and testbench
======================================

Name: pipe_stage_skid_reg

Overview:
- Parametrised successor to the per-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- One generic stage register with a valid/ready handshake, a 2-entry skid buffer and a flush (bubble-insert) input.
- Carries an opaque payload plus a saturating-decremented tNew field, so every pipeline boundary uses the same block instead of hand-written per-stage registers.
- in_ready is registered: it never depends combinationally on out_ready, which breaks the long stall path across stages.

Parameters:
- DATA_W, 96: payload width in bits (command, address, control, data packed by the instantiating stage).
- TNEW_W, 3: width of the tNew hazard counter field.
- ZERO_ON_BUBBLE, 1: if 1, out_data and out_tnew read 0 whenever out_valid=0 (a nop-encoded bubble). If 0, they hold their last value.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high; clears all state.
- flush  in  1  synchronous; discards both entries and any same-cycle input.
- in_valid  in  1  upstream has a payload.
- in_ready  out  1  stage can accept a payload (registered).
- in_data  in  DATA_W  upstream payload.
- in_tnew  in  TNEW_W  upstream tNew.
- out_valid  out  1  output entry holds a payload.
- out_ready  in  1  downstream accepts (0 = stall).
- out_data  out  DATA_W  output payload.
- out_tnew  out  TNEW_W  tNew of the output entry, already decremented.
- occupancy  out  2  number of valid entries (0..2).

Behaviour:
- Storage:
  - Main entry M (drives the out_* ports) and skid entry S, each with a valid bit.
  - in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Combinational outputs:
  - out_valid = M.valid; in_ready = !S.valid; occupancy = M.valid + S.valid.
  - All of these are driven directly from flops.
- Capture rule: on in_fire, the stored tNew = (in_tnew==0) ? 0 : in_tnew-1, with no wrap. The decrement applies only on capture from the input, never on an S->M move.
- Priority order: reset > flush > normal update.
- Reset (registered, next edge):
  - M.valid=0, S.valid=0, M/S data=0, M/S tnew=0.
  - Hence out_valid=0, out_data=0, out_tnew=0, in_ready=1, occupancy=0.
  - Reset asserted mid-transfer drops everything, including a same-cycle in_fire.
- Flush (next edge):
  - M.valid=0 and S.valid=0.
  - A same-cycle in_fire is accepted by the handshake but discarded.
  - With ZERO_ON_BUBBLE=1, the M data/tnew registers are cleared to 0.
  - in_ready=1 in the following cycle.
- Normal update, evaluated each edge:
  - M empty or out_fire, S valid: M<=S. S<=captured input if in_fire, else S.valid=0.
  - M empty or out_fire, S empty: M<=captured input if in_fire, else M.valid=0 (bubble).
  - M valid and !out_fire: M holds. If in_fire, S<=captured input; this is only possible when S is empty.
- Ordering and loss:
  - Payloads leave in acceptance order.
  - No payload is lost or duplicated.
  - Full (occupancy=2) forces in_ready=0 from the next cycle.
- Bubble zeroing: with ZERO_ON_BUBBLE=1, whenever M becomes invalid its data/tnew are written to 0. The skid register is not visible and need not be zeroed, except on reset.
- Latency and throughput:
  - Latency is 1 cycle, input accept to out_valid, when the stage is empty.
  - Sustained throughput is 1 payload/cycle with out_ready=1.
  - After a one-cycle stall, one entry sits in S and drains without a throughput loss.
- Simultaneous stall and flush: flush wins; the entries are dropped even when out_ready=0.

Test Plan:
- Reset, then in_valid=1, in_data=0x1234, in_tnew=2, out_ready=1 → next cycle out_valid=1, out_data=0x1234, out_tnew=1, occupancy=1.
- Saturation: in_tnew=0 → out_tnew=0. in_tnew=7 (TNEW_W=3) → out_tnew=6. The tnew of a payload that moves S->M is unchanged.
- Back-pressure: stream A,B,C with out_ready=0 from the cycle after A is accepted.
  - Required: occupancy=2 and in_ready=0; C is not accepted.
  - Then out_ready=1: outputs A,B,C in order, one per cycle, none lost.
- Flush with occupancy=2, in_valid=1, out_ready=0 → next cycle out_valid=0, occupancy=0, out_data=0, out_tnew=0, in_ready=1; the same-cycle input never appears at the output.
- Reset asserted while flush=1 and in_fire=1 → all outputs are at their reset values the next cycle. Deassert reset → the first accepted payload appears 1 cycle later.
- ZERO_ON_BUBBLE=0: accept 0xBEEF, drain it, then idle → out_valid=0 while out_data holds 0xBEEF.

Source files
------------

// File: rtl/pipe_stage_skid_reg.sv
// rtl/pipe_stage_skid_reg.sv - generic valid/ready pipeline stage register with a 2-entry skid buffer
// Main entry M drives the outputs and skid entry S absorbs one payload while M is stalled.
module pipe_stage_skid_reg #(
  parameter int DATA_W         = 96,
  parameter int TNEW_W         = 3,
  parameter bit ZERO_ON_BUBBLE = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [TNEW_W-1:0] in_tnew,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [TNEW_W-1:0] out_tnew,
  output logic [1:0]        occupancy
);

  logic              m_valid;
  logic [DATA_W-1:0] m_data;
  logic [TNEW_W-1:0] m_tnew;
  logic              s_valid;
  logic [DATA_W-1:0] s_data;
  logic [TNEW_W-1:0] s_tnew;

  logic              in_fire;
  logic              out_fire;
  logic              m_free;
  logic [TNEW_W-1:0] cap_tnew;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = m_valid & out_ready;
  assign m_free   = !m_valid || out_fire;

  // tNew only counts down on capture from upstream and saturates at zero.
  assign cap_tnew = (in_tnew == '0) ? '0 : in_tnew - TNEW_W'(1);

  // Every output comes straight from a flop so no stall path crosses the stage.
  assign in_ready  = !s_valid;
  assign out_valid = m_valid;
  assign out_data  = m_data;
  assign out_tnew  = m_tnew;
  assign occupancy = 2'(m_valid) + 2'(s_valid);

  always_ff @(posedge clk) begin
    if (reset) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_tnew  <= '0;
      s_valid <= 1'b0;
      s_data  <= '0;
      s_tnew  <= '0;
    end else if (flush) begin
      m_valid <= 1'b0;
      s_valid <= 1'b0;
      if (ZERO_ON_BUBBLE) begin
        m_data <= '0;
        m_tnew <= '0;
      end
    end else if (m_free) begin
      if (s_valid) begin
        m_valid <= 1'b1;
        m_data  <= s_data;
        m_tnew  <= s_tnew;
        if (in_fire) begin
          s_data <= in_data;
          s_tnew <= cap_tnew;
        end else begin
          s_valid <= 1'b0;
        end
      end else if (in_fire) begin
        m_valid <= 1'b1;
        m_data  <= in_data;
        m_tnew  <= cap_tnew;
      end else begin
        m_valid <= 1'b0;
        if (ZERO_ON_BUBBLE) begin
          m_data <= '0;
          m_tnew <= '0;
        end
      end
    end else if (in_fire) begin
      // M is stalled; in_fire implies S is empty because in_ready = !s_valid.
      s_valid <= 1'b1;
      s_data  <= in_data;
      s_tnew  <= cap_tnew;
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// tb/tb_pipe_stage_skid_reg.sv - directed self-checking bench for pipe_stage_skid_reg
// A second instance with ZERO_ON_BUBBLE=0 shares the inputs to check the hold-last-value variant.
module tb_pipe_stage_skid_reg;

  localparam int DATA_W = 96;
  localparam int TNEW_W = 3;

  logic              clk = 1'b0;
  logic              reset, flush, in_valid, out_ready;
  logic [DATA_W-1:0] in_data;
  logic [TNEW_W-1:0] in_tnew;

  logic              in_ready, out_valid;
  logic [DATA_W-1:0] out_data;
  logic [TNEW_W-1:0] out_tnew;
  logic [1:0]        occupancy;

  logic              in_ready2, out_valid2;
  logic [DATA_W-1:0] out_data2;
  logic [TNEW_W-1:0] out_tnew2;
  logic [1:0]        occupancy2;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  pipe_stage_skid_reg #(.DATA_W(DATA_W), .TNEW_W(TNEW_W), .ZERO_ON_BUBBLE(1'b1)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_tnew(in_tnew),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tnew(out_tnew),
    .occupancy(occupancy)
  );

  pipe_stage_skid_reg #(.DATA_W(DATA_W), .TNEW_W(TNEW_W), .ZERO_ON_BUBBLE(1'b0)) dut_hold (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready2), .in_data(in_data), .in_tnew(in_tnew),
    .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2), .out_tnew(out_tnew2),
    .occupancy(occupancy2)
  );

  // Advance one edge and settle; outputs read afterwards reflect that edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_data = '0; in_tnew = '0;
    tick(); tick();
    total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %0b want 0", out_valid); else passed++;
    total++; if (out_data !== '0) $display("FAIL reset_out_data: got %0h want 0", out_data); else passed++;
    total++; if (out_tnew !== '0) $display("FAIL reset_out_tnew: got %0d want 0", out_tnew); else passed++;
    total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %0b want 1", in_ready); else passed++;
    total++; if (occupancy !== 2'd0) $display("FAIL reset_occupancy: got %0d want 0", occupancy); else passed++;
    reset = 1'b0;
  endtask

  task automatic test_single();
    in_valid = 1'b1; in_data = 96'h1234; in_tnew = 3'd2; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b1) $display("FAIL single_valid: got %0b want 1", out_valid); else passed++;
    total++; if (out_data !== 96'h1234) $display("FAIL single_data: got %0h want 1234", out_data); else passed++;
    total++; if (out_tnew !== 3'd1) $display("FAIL single_tnew: got %0d want 1", out_tnew); else passed++;
    total++; if (occupancy !== 2'd1) $display("FAIL single_occupancy: got %0d want 1", occupancy); else passed++;
    tick();
    total++; if (out_valid !== 1'b0) $display("FAIL single_drain_valid: got %0b want 0", out_valid); else passed++;
    total++; if (out_data !== '0) $display("FAIL single_bubble_data: got %0h want 0", out_data); else passed++;
  endtask

  task automatic test_saturation();
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 96'h11; in_tnew = 3'd0;
    tick();
    total++; if (out_tnew !== 3'd0) $display("FAIL sat_tnew0: got %0d want 0", out_tnew); else passed++;
    in_data = 96'h22; in_tnew = 3'd7;
    tick();
    total++; if (out_tnew !== 3'd6) $display("FAIL sat_tnew7: got %0d want 6", out_tnew); else passed++;
    total++; if (out_data !== 96'h22) $display("FAIL sat_data7: got %0h want 22", out_data); else passed++;
    // A arrives with tnew 5 (stored 4); B is parked in S with tnew 3 (stored 2) while M stalls.
    in_data = 96'hA5; in_tnew = 3'd5;
    tick();
    out_ready = 1'b0; in_data = 96'hB3; in_tnew = 3'd3;
    tick();
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    total++; if (out_data !== 96'hB3) $display("FAIL skid_move_data: got %0h want b3", out_data); else passed++;
    total++; if (out_tnew !== 3'd2) $display("FAIL skid_move_tnew: got %0d want 2", out_tnew); else passed++;
    tick();
  endtask

  task automatic test_back_pressure();
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 96'hA; in_tnew = 3'd1;
    tick();
    out_ready = 1'b0; in_data = 96'hB;
    tick();
    total++; if (occupancy !== 2'd2) $display("FAIL bp_occupancy_full: got %0d want 2", occupancy); else passed++;
    total++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready_full: got %0b want 0", in_ready); else passed++;
    in_data = 96'hC;
    tick();
    total++; if (occupancy !== 2'd2) $display("FAIL bp_c_refused_occ: got %0d want 2", occupancy); else passed++;
    total++; if (out_data !== 96'hA) $display("FAIL bp_hold_a: got %0h want a", out_data); else passed++;
    out_ready = 1'b1;
    tick();
    total++; if (out_data !== 96'hB) $display("FAIL bp_out_b: got %0h want b", out_data); else passed++;
    total++; if (in_ready !== 1'b1) $display("FAIL bp_in_ready_reopen: got %0b want 1", in_ready); else passed++;
    tick();
    in_valid = 1'b0;
    total++; if (out_data !== 96'hC || out_valid !== 1'b1) $display("FAIL bp_out_c: got %0h/%0b want c/1", out_data, out_valid); else passed++;
    tick();
    total++; if (out_valid !== 1'b0) $display("FAIL bp_drained: got %0b want 0", out_valid); else passed++;
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = DATA_W'(32'h100 + i); in_tnew = 3'd4;
      tick();
      total++;
      if (out_valid !== 1'b1 || out_data !== DATA_W'(32'h100 + i))
        $display("FAIL b2b_%0d: got %0h/%0b want %0h/1", i, out_data, out_valid, 32'h100 + i);
      else passed++;
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_flush();
    out_ready = 1'b1; in_valid = 1'b1; in_data = 96'h51; in_tnew = 3'd3;
    tick();
    out_ready = 1'b0; in_data = 96'h52;
    tick();
    flush = 1'b1; in_valid = 1'b1; in_data = 96'h53;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    total++; if (out_valid !== 1'b0) $display("FAIL flush_valid: got %0b want 0", out_valid); else passed++;
    total++; if (occupancy !== 2'd0) $display("FAIL flush_occupancy: got %0d want 0", occupancy); else passed++;
    total++; if (out_data !== '0 || out_tnew !== '0) $display("FAIL flush_zero: got %0h/%0d want 0/0", out_data, out_tnew); else passed++;
    total++; if (in_ready !== 1'b1) $display("FAIL flush_in_ready: got %0b want 1", in_ready); else passed++;
    // Flush on an empty stage with a real in_fire: the payload is swallowed.
    out_ready = 1'b1; flush = 1'b1; in_valid = 1'b1; in_data = 96'h54;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    tick();
    total++; if (out_valid !== 1'b0 || occupancy !== 2'd0) $display("FAIL flush_discard_input: got %0b/%0d want 0/0", out_valid, occupancy); else passed++;
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 96'h61; in_tnew = 3'd2;
    tick();
    reset = 1'b1; flush = 1'b1; in_data = 96'h62;
    tick();
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0;
    total++; if (out_valid !== 1'b0 || out_data !== '0 || out_tnew !== '0)
      $display("FAIL rst_mid_out: got %0b/%0h/%0d want 0/0/0", out_valid, out_data, out_tnew); else passed++;
    total++; if (in_ready !== 1'b1 || occupancy !== 2'd0)
      $display("FAIL rst_mid_ctrl: got %0b/%0d want 1/0", in_ready, occupancy); else passed++;
    out_ready = 1'b1; in_valid = 1'b1; in_data = 96'h77; in_tnew = 3'd3;
    tick();
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b1 || out_data !== 96'h77 || out_tnew !== 3'd2)
      $display("FAIL rst_mid_first: got %0b/%0h/%0d want 1/77/2", out_valid, out_data, out_tnew); else passed++;
    tick();
  endtask

  task automatic test_no_zero();
    out_ready = 1'b1; in_valid = 1'b1; in_data = 96'hBEEF; in_tnew = 3'd4;
    tick();
    in_valid = 1'b0;
    total++; if (out_valid2 !== 1'b1 || out_data2 !== 96'hBEEF) $display("FAIL hold_accept: got %0b/%0h want 1/beef", out_valid2, out_data2); else passed++;
    tick(); tick();
    total++; if (out_valid2 !== 1'b0) $display("FAIL hold_valid: got %0b want 0", out_valid2); else passed++;
    total++; if (out_data2 !== 96'hBEEF || out_tnew2 !== 3'd3) $display("FAIL hold_data: got %0h/%0d want beef/3", out_data2, out_tnew2); else passed++;
    total++; if (in_ready2 !== 1'b1 || occupancy2 !== 2'd0) $display("FAIL hold_ctrl: got %0b/%0d want 1/0", in_ready2, occupancy2); else passed++;
    total++; if (out_data !== '0) $display("FAIL zero_variant_data: got %0h want 0", out_data); else passed++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_saturation();
    test_back_pressure();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    test_no_zero();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
